// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the burst-length lookup used by the arbiter.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

    localparam int BEAT_CNT_W = 5;

    // Number of beats in a fixed-length burst; INCR reports 1 so the
    // beat counter loads 0 and the open-burst flag takes over.
    function automatic logic [BEAT_CNT_W-1:0] burst_len(input hburst_t hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
            default:                      burst_len = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the
// interconnect master port. 'slave' is the arbiter's view; 'master' is the
// view of everything around it (masters plus interconnect).
interface ahb_master_arbiter_if #(
    parameter int MASTER_NUM         = 2,
    parameter int C_S_AHB_DATA_WIDTH = 32,
    parameter int C_S_AHB_ADDR_WIDTH = 32
);
    localparam int AW = C_S_AHB_ADDR_WIDTH;
    localparam int DW = C_S_AHB_DATA_WIDTH;

    logic [MASTER_NUM-1:0]    MX_HBUSREQ;
    logic [MASTER_NUM-1:0]    MX_HLOCK;
    logic [MASTER_NUM-1:0]    MX_HGRANT;
    logic [1:0]               MX_HMASTER;
    logic [MASTER_NUM*AW-1:0] MX_HADDR;
    logic [MASTER_NUM*2-1:0]  MX_HTRANS;
    logic [MASTER_NUM-1:0]    MX_HWRITE;
    logic [MASTER_NUM*3-1:0]  MX_HSIZE;
    logic [MASTER_NUM*3-1:0]  MX_HBURST;
    logic [MASTER_NUM*4-1:0]  MX_HPORT;
    logic [MASTER_NUM*DW-1:0] MX_HWDATA;
    logic [DW-1:0]            MX_HRDATA;
    logic                     MX_HREADY;
    logic [1:0]               MX_HRESP;

    logic [AW-1:0]            M_HADDR;
    logic [1:0]               M_HTRANS;
    logic                     M_HWRITE;
    logic [2:0]               M_HSIZE;
    logic [2:0]               M_HBURST;
    logic [3:0]               M_HPORT;
    logic [DW-1:0]            M_HWDATA;
    logic [DW-1:0]            M_HRDATA;
    logic [1:0]               S2M_HRESP;
    logic                     S2M_HREAD_o;

    modport slave (
        input  MX_HBUSREQ, MX_HLOCK, MX_HADDR, MX_HTRANS, MX_HWRITE, MX_HSIZE,
               MX_HBURST, MX_HPORT, MX_HWDATA, M_HRDATA, S2M_HRESP, S2M_HREAD_o,
        output MX_HGRANT, MX_HMASTER, MX_HRDATA, MX_HREADY, MX_HRESP,
               M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HBURST, M_HPORT, M_HWDATA
    );

    modport master (
        output MX_HBUSREQ, MX_HLOCK, MX_HADDR, MX_HTRANS, MX_HWRITE, MX_HSIZE,
               MX_HBURST, MX_HPORT, MX_HWDATA, M_HRDATA, S2M_HRESP, S2M_HREAD_o,
        input  MX_HGRANT, MX_HMASTER, MX_HRDATA, MX_HREADY, MX_HRESP,
               M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HBURST, M_HPORT, M_HWDATA
    );

endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin selector: first requester above ptr, wrapping
// around to index 0 and finally ptr itself.
module ahb_rr_picker #(
    parameter int MASTER_NUM = 2
) (
    input  logic [MASTER_NUM-1:0] req,
    input  logic [1:0]            ptr,
    output logic [MASTER_NUM-1:0] gnt,
    output logic                  valid
);

    // Two passes: indices above the pointer first, then the wrapped part.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        for (int j = 0; j < MASTER_NUM; j++) begin
            if (!valid && req[j] && (2'(j) > ptr)) begin
                gnt[j] = 1'b1;
                valid  = 1'b1;
            end
        end
        for (int j = 0; j < MASTER_NUM; j++) begin
            if (!valid && req[j] && (2'(j) <= ptr)) begin
                gnt[j] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB arbiter and address/write-data mux for several masters
// sharing one interconnect master port.
//
// Grant FSM (state is the one-hot grant vector)
//   state          | meaning
//   grant[i] = 1   | master i owns the next address phase once HREADY is high
//   grant = DEFAULT| nobody requesting, bus parked on DEFAULT_MASTER
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int MASTER_NUM         = 2,
    parameter int C_S_AHB_DATA_WIDTH = 32,
    parameter int C_S_AHB_ADDR_WIDTH = 32,
    parameter int DEFAULT_MASTER     = 0
) (
    input  logic                 HCLK,
    input  logic                 H_nREST,
    ahb_master_arbiter_if.slave  bus
);

    localparam int AW = C_S_AHB_ADDR_WIDTH;
    localparam int DW = C_S_AHB_DATA_WIDTH;
    localparam logic [1:0] DEF_IDX = 2'(DEFAULT_MASTER);
    localparam logic [MASTER_NUM-1:0] DEF_GRANT =
        {{(MASTER_NUM-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

    logic [MASTER_NUM-1:0]   grant_q, grant_d, pick_gnt;
    logic                    pick_valid;
    logic [1:0]              hmaster_q, downer_q, ptr_q, ptr_d, grant_idx, pick_idx;
    logic [BEAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    open_q, open_d, lock_q, lock_d, rearb;

    logic [AW-1:0]           o_addr;
    htrans_t                 o_trans;
    hburst_t                 o_burst;
    logic                    o_write, o_lock;
    logic [2:0]              o_size;
    logic [3:0]              o_port;
    logic [DW-1:0]           o_wdata;

    // Select address-phase signals of the owner and write data of the data-phase owner.
    always_comb begin
        o_addr  = '0;
        o_trans = HTRANS_IDLE;
        o_burst = HBURST_SINGLE;
        o_write = 1'b0;
        o_lock  = 1'b0;
        o_size  = '0;
        o_port  = '0;
        o_wdata = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (hmaster_q == 2'(i)) begin
                o_addr  = bus.MX_HADDR[i*AW +: AW];
                o_trans = htrans_t'(bus.MX_HTRANS[i*2 +: 2]);
                o_burst = hburst_t'(bus.MX_HBURST[i*3 +: 3]);
                o_write = bus.MX_HWRITE[i];
                o_lock  = bus.MX_HLOCK[i];
                o_size  = bus.MX_HSIZE[i*3 +: 3];
                o_port  = bus.MX_HPORT[i*4 +: 4];
            end
            if (downer_q == 2'(i)) begin
                o_wdata = bus.MX_HWDATA[i*DW +: DW];
            end
        end
    end

    // Encode the current grant and the picker result as master indices.
    always_comb begin
        grant_idx = DEF_IDX;
        pick_idx  = DEF_IDX;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (grant_q[i])  grant_idx = 2'(i);
            if (pick_gnt[i]) pick_idx  = 2'(i);
        end
    end

    // Track beats left in the owner's burst and decide whether this edge may re-arbitrate.
    always_comb begin
        cnt_d  = cnt_q;
        open_d = open_q;
        lock_d = lock_q;
        rearb  = 1'b0;
        if (bus.S2M_HREAD_o) begin
            case (o_trans)
                HTRANS_NONSEQ: begin
                    cnt_d  = burst_len(o_burst) - 5'd1;
                    open_d = (o_burst == HBURST_INCR);
                    lock_d = o_lock;
                end
                HTRANS_SEQ:  if (cnt_q != '0) cnt_d = cnt_q - 5'd1;
                HTRANS_IDLE: open_d = 1'b0;
                default:     ;
            endcase
            if (bus.S2M_HRESP == HRESP_ERROR) begin
                cnt_d  = '0;
                open_d = 1'b0;
            end
            // Lock is judged on the value that takes effect with this beat so a
            // locked sequence starting from an unlocked bus is never split.
            rearb = !lock_d &&
                    ((o_trans == HTRANS_IDLE) ||
                     (((o_trans == HTRANS_NONSEQ) || (o_trans == HTRANS_SEQ)) &&
                      (cnt_d == '0) && !open_d) ||
                     (bus.S2M_HRESP == HRESP_ERROR));
        end
    end

    ahb_rr_picker #(.MASTER_NUM(MASTER_NUM)) u_picker (
        .req   (bus.MX_HBUSREQ),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // Grant FSM next state: move at a re-arbitration point, park when idle.
    always_comb begin
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (rearb) begin
            if (pick_valid) begin
                grant_d = pick_gnt;
                ptr_d   = pick_idx;
            end else begin
                grant_d = DEF_GRANT;
            end
        end
    end

    // State registers; ownership pipeline advances only on HREADY.
    always_ff @(posedge HCLK or negedge H_nREST) begin
        if (!H_nREST) begin
            grant_q   <= DEF_GRANT;
            hmaster_q <= DEF_IDX;
            downer_q  <= DEF_IDX;
            ptr_q     <= DEF_IDX;
            cnt_q     <= '0;
            open_q    <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            open_q  <= open_d;
            lock_q  <= lock_d;
            if (bus.S2M_HREAD_o) begin
                hmaster_q <= grant_idx;
                downer_q  <= hmaster_q;
            end
        end
    end

    assign bus.MX_HGRANT  = grant_q;
    assign bus.MX_HMASTER = hmaster_q;
    assign bus.MX_HRDATA  = bus.M_HRDATA;
    assign bus.MX_HREADY  = bus.S2M_HREAD_o;
    assign bus.MX_HRESP   = bus.S2M_HRESP;
    assign bus.M_HADDR    = o_addr;
    assign bus.M_HTRANS   = o_trans;
    assign bus.M_HWRITE   = o_write;
    assign bus.M_HSIZE    = o_size;
    assign bus.M_HBURST   = o_burst;
    assign bus.M_HPORT    = o_port;
    assign bus.M_HWDATA   = o_wdata;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter with two masters.
module tb_ahb_master_arbiter;
    import ahb_pkg::*;

    localparam int MN = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] M0_ADDR = 32'h0000_8000;

    logic HCLK = 1'b0;
    logic H_nREST = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 HCLK = ~HCLK;

    ahb_master_arbiter_if #(.MASTER_NUM(MN), .C_S_AHB_DATA_WIDTH(DW),
                            .C_S_AHB_ADDR_WIDTH(AW)) bus ();

    ahb_master_arbiter #(.MASTER_NUM(MN), .C_S_AHB_DATA_WIDTH(DW),
                         .C_S_AHB_ADDR_WIDTH(AW), .DEFAULT_MASTER(0)) dut (
        .HCLK    (HCLK),
        .H_nREST (H_nREST),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input int m, input logic [1:0] trans, input logic [2:0] burst,
                         input logic [31:0] addr, input logic lock);
        bus.MX_HTRANS[m*2 +: 2]  = trans;
        bus.MX_HBURST[m*3 +: 3]  = burst;
        bus.MX_HADDR[m*AW +: AW] = addr;
        bus.MX_HLOCK[m]          = lock;
    endtask

    task automatic set_wdata(input int m, input logic [31:0] d);
        bus.MX_HWDATA[m*DW +: DW] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g [4];
        logic [1:0] exp_m [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_m = '{2'd1, 2'd0, 2'd1, 2'd0};

        bus.MX_HBUSREQ = '0; bus.MX_HLOCK = '0; bus.MX_HADDR = '0; bus.MX_HTRANS = '0;
        bus.MX_HWRITE = 2'b10; bus.MX_HSIZE = {3'd1, 3'd2}; bus.MX_HBURST = '0;
        bus.MX_HPORT = {4'hA, 4'h3}; bus.MX_HWDATA = '0;
        bus.M_HRDATA = 32'hdead_beef; bus.S2M_HRESP = 2'b00; bus.S2M_HREAD_o = 1'b1;
        drive(0, HTRANS_IDLE, HBURST_SINGLE, 32'h0000_1000, 1'b0);
        drive(1, HTRANS_IDLE, HBURST_SINGLE, 32'h2000_0010, 1'b0);
        set_wdata(0, 32'haaaa_0000);
        set_wdata(1, 32'h1111_1111);

        // reset state and pass-through
        #12;
        chk("rst_grant", bus.MX_HGRANT, 2'b01);
        chk("rst_hmaster", bus.MX_HMASTER, 2'd0);
        chk("rst_htrans", bus.M_HTRANS, HTRANS_IDLE);
        chk("rst_haddr", bus.M_HADDR, 32'h0000_1000);
        chk("rst_hsize", bus.M_HSIZE, 3'd2);
        chk("pt_hrdata", bus.MX_HRDATA, 32'hdead_beef);
        chk("pt_hready", bus.MX_HREADY, 1'b1);
        H_nREST = 1'b1;
        tick();
        chk("park_grant", bus.MX_HGRANT, 2'b01);

        // M1 alone requests
        bus.MX_HBUSREQ = 2'b10;
        #1;
        chk("no_early_grant", bus.MX_HGRANT, 2'b01);
        tick();
        chk("m1_grant", bus.MX_HGRANT, 2'b10);
        chk("m1_hmaster_lag", bus.MX_HMASTER, 2'd0);
        tick();
        chk("m1_hmaster", bus.MX_HMASTER, 2'd1);
        chk("m1_haddr", bus.M_HADDR, 32'h2000_0010);
        chk("m1_hsize", bus.M_HSIZE, 3'd1);
        chk("m1_hport", bus.M_HPORT, 4'hA);
        chk("m1_hwrite", bus.M_HWRITE, 1'b1);
        drive(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h2000_0010, 1'b0);
        #1;
        chk("m1_htrans", bus.M_HTRANS, HTRANS_NONSEQ);
        tick();
        chk("m1_hwdata", bus.M_HWDATA, 32'h1111_1111);
        chk("m1_grant_hold", bus.MX_HGRANT, 2'b10);

        // both request SINGLEs: ownership alternates
        bus.MX_HBUSREQ = 2'b11;
        drive(0, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0000_1000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("alt_grant", bus.MX_HGRANT, exp_g[k]);
            chk("alt_hmaster", bus.MX_HMASTER, exp_m[k]);
            chk("alt_haddr", bus.M_HADDR, (exp_m[k] == 2'd1) ? 32'h2000_0010 : 32'h0000_1000);
        end
        bus.MX_HBUSREQ = 2'b00;
        drive(0, HTRANS_IDLE, HBURST_SINGLE, 32'h0000_1000, 1'b0);
        drive(1, HTRANS_IDLE, HBURST_SINGLE, 32'h2000_0010, 1'b0);
        tick();
        tick();
        chk("idle_grant", bus.MX_HGRANT, 2'b01);
        chk("idle_hmaster", bus.MX_HMASTER, 2'd0);

        // M0 INCR4 with two wait states while M1 requests
        bus.MX_HBUSREQ = 2'b10;
        drive(0, HTRANS_NONSEQ, HBURST_INCR4, 32'h43c0_0000, 1'b0);
        tick();
        chk("incr4_b1", bus.MX_HGRANT, 2'b01);
        drive(0, HTRANS_SEQ, HBURST_INCR4, 32'h43c0_0004, 1'b0);
        set_wdata(0, 32'hc0de_0001);
        bus.S2M_HREAD_o = 1'b0;
        #1;
        chk("incr4_wd1", bus.M_HWDATA, 32'hc0de_0001);
        tick();
        tick();
        chk("incr4_wait_grant", bus.MX_HGRANT, 2'b01);
        chk("incr4_wait_hmaster", bus.MX_HMASTER, 2'd0);
        bus.S2M_HREAD_o = 1'b1;
        tick();
        chk("incr4_b2", bus.MX_HGRANT, 2'b01);
        drive(0, HTRANS_SEQ, HBURST_INCR4, 32'h43c0_0008, 1'b0);
        set_wdata(0, 32'hc0de_0002);
        tick();
        drive(0, HTRANS_SEQ, HBURST_INCR4, 32'h43c0_000c, 1'b0);
        set_wdata(0, 32'hc0de_0003);
        #1;
        chk("incr4_haddr4", bus.M_HADDR, 32'h43c0_000c);
        chk("incr4_b3", bus.MX_HGRANT, 2'b01);
        tick();
        chk("incr4_handover", bus.MX_HGRANT, 2'b10);
        chk("incr4_hmaster", bus.MX_HMASTER, 2'd0);
        drive(0, HTRANS_IDLE, HBURST_SINGLE, M0_ADDR, 1'b0);
        set_wdata(0, 32'hc0de_0004);
        #1;
        chk("incr4_wd4", bus.M_HWDATA, 32'hc0de_0004);
        tick();
        chk("incr4_m1_owner", bus.MX_HMASTER, 2'd1);
        chk("incr4_wd_owner0", bus.M_HWDATA, 32'hc0de_0004);
        tick();
        chk("incr4_wd_owner1", bus.M_HWDATA, 32'h1111_1111);
        bus.MX_HBUSREQ = 2'b00;
        tick();
        tick();

        // M0 locked INCR8 then locked SINGLE, M1 requesting
        bus.MX_HBUSREQ = 2'b10;
        drive(0, HTRANS_NONSEQ, HBURST_INCR8, M0_ADDR, 1'b1);
        tick();
        chk("lock_b1", bus.MX_HGRANT, 2'b01);
        for (int k = 0; k < 7; k++) begin
            drive(0, HTRANS_SEQ, HBURST_INCR8, M0_ADDR + 32'(4 * (k + 1)), 1'b1);
            tick();
            chk("lock_burst", bus.MX_HGRANT, 2'b01);
        end
        drive(0, HTRANS_NONSEQ, HBURST_SINGLE, M0_ADDR, 1'b1);
        tick();
        chk("lock_single", bus.MX_HGRANT, 2'b01);
        drive(0, HTRANS_IDLE, HBURST_SINGLE, M0_ADDR, 1'b1);
        tick();
        chk("lock_idle", bus.MX_HGRANT, 2'b01);
        drive(0, HTRANS_NONSEQ, HBURST_SINGLE, M0_ADDR, 1'b0);
        tick();
        chk("lock_release", bus.MX_HGRANT, 2'b10);
        drive(0, HTRANS_IDLE, HBURST_SINGLE, M0_ADDR, 1'b0);
        tick();
        chk("lock_m1_owner", bus.MX_HMASTER, 2'd1);

        // ERROR on beat 2 of M1 INCR8 hands the bus to M0
        bus.MX_HBUSREQ = 2'b01;
        drive(1, HTRANS_NONSEQ, HBURST_INCR8, 32'h5000_0000, 1'b0);
        tick();
        chk("err_b1", bus.MX_HGRANT, 2'b10);
        drive(1, HTRANS_SEQ, HBURST_INCR8, 32'h5000_0004, 1'b0);
        bus.S2M_HRESP = HRESP_ERROR;
        #1;
        chk("pt_hresp", bus.MX_HRESP, 2'b01);
        tick();
        chk("err_handover", bus.MX_HGRANT, 2'b01);
        chk("err_hmaster", bus.MX_HMASTER, 2'd1);
        bus.S2M_HRESP = HRESP_OKAY;

        // reset pulse in the middle of a locked M1 INCR16
        bus.MX_HBUSREQ = 2'b10;
        drive(1, HTRANS_IDLE, HBURST_SINGLE, 32'h6000_0000, 1'b0);
        tick();
        tick();
        chk("rst_pre_hmaster", bus.MX_HMASTER, 2'd1);
        drive(1, HTRANS_NONSEQ, HBURST_INCR16, 32'h6000_0000, 1'b1);
        set_wdata(0, 32'haaaa_aaaa);
        set_wdata(1, 32'hbbbb_bbbb);
        tick();
        drive(1, HTRANS_SEQ, HBURST_INCR16, 32'h6000_0004, 1'b1);
        tick();
        chk("burst_grant", bus.MX_HGRANT, 2'b10);
        chk("burst_hwdata", bus.M_HWDATA, 32'hbbbb_bbbb);
        #2;
        H_nREST = 1'b0;
        #1;
        chk("async_rst_grant", bus.MX_HGRANT, 2'b01);
        chk("async_rst_hmaster", bus.MX_HMASTER, 2'd0);
        chk("async_rst_hwdata", bus.M_HWDATA, 32'haaaa_aaaa);
        chk("async_rst_haddr", bus.M_HADDR, M0_ADDR);
        #2;
        H_nREST = 1'b1;
        tick();
        chk("post_rst_regrant", bus.MX_HGRANT, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
